// File: rtl/fmdll_lock_ctrl.sv
// Lock controller for the frequency-multiplying DLL: SAR acquisition of the DCDL
// code, +/-1 tracking with periodic clk_ext re-injection, lock/loss detection and hold.
module fmdll_lock_ctrl #(
  parameter int CODE_W   = 10,
  parameter int M_W      = 2,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              hold_req,
  input  logic [M_W-1:0]    m_div,
  input  logic              pd_valid,
  input  logic              pd_late,
  output logic [CODE_W-1:0] code,
  output logic [1:0]        sel,
  output logic              locked,
  output logic              lock_lost,
  output logic [1:0]        state
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W = $clog2(LOSS_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
  localparam logic [REV_W-1:0]  REV_MAX  = REV_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SAR   = 2'b01,
    S_TRACK = 2'b10,
    S_HOLD  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SEL_RECIRC = 2'b00,
    SEL_INJECT = 2'b01,
    SEL_GATE   = 2'b10
  } sel_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  sel_e              sel_q, sel_d;
  logic              locked_q, locked_d;
  logic              lost_q, lost_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [M_W-1:0]    cnt_q, cnt_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              dir_q, dir_d;     // direction of the previous tracking step (1 = late)
  logic              first_q, first_d; // next tracking step only records its direction

  logic [REV_W-1:0]  rev_inc;
  logic [RUN_W-1:0]  run_inc;

  assign rev_inc = (rev_q == REV_MAX) ? REV_MAX : rev_q + 1'b1;
  assign run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d  = state_q;
    code_d   = code_q;
    locked_d = locked_q;
    lost_d   = 1'b0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rev_d    = rev_q;
    run_d    = run_q;
    dir_d    = dir_q;
    first_d  = first_q;

    if (!en) begin
      state_d  = S_IDLE;
      code_d   = CODE_MID;
      locked_d = 1'b0;
      idx_d    = IDX_TOP;
      cnt_d    = '0;
      rev_d    = '0;
      run_d    = '0;
      dir_d    = 1'b0;
      first_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SAR;
          code_d  = CODE_MID;
          idx_d   = IDX_TOP;
        end
        S_SAR: begin
          if (hold_req) begin
            state_d = S_HOLD;
          end else if (pd_valid) begin
            if (pd_late) code_d[idx_q] = 1'b0;
            if (idx_q != '0) begin
              code_d[idx_q - 1'b1] = 1'b1;
              idx_d = idx_q - 1'b1;
            end else begin
              state_d = S_TRACK;
              cnt_d   = '0;
              first_d = 1'b1;
            end
          end
        end
        S_TRACK: begin
          if (hold_req) begin
            state_d = S_HOLD;
          end else begin
            cnt_d = (cnt_q >= m_div) ? '0 : cnt_q + 1'b1;
            if (pd_valid) begin
              if (pd_late) code_d = (code_q == '0) ? code_q : code_q - 1'b1;
              else         code_d = (code_q == '1) ? code_q : code_q + 1'b1;
              dir_d = pd_late;
              if (first_q) begin
                first_d = 1'b0;
              end else if (pd_late != dir_q) begin
                rev_d = rev_inc;
                run_d = RUN_W'(1);
                if (rev_inc == REV_MAX) locked_d = 1'b1;
              end else begin
                run_d = run_inc;
                rev_d = '0;
                // A long one-sided run only matters once lock has been declared.
                if (run_inc == RUN_MAX && locked_q) begin
                  state_d  = S_SAR;
                  code_d   = CODE_MID;
                  idx_d    = IDX_TOP;
                  locked_d = 1'b0;
                  lost_d   = 1'b1;
                  cnt_d    = '0;
                  rev_d    = '0;
                  run_d    = '0;
                  dir_d    = 1'b0;
                  first_d  = 1'b1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (!hold_req) begin
            state_d = S_TRACK;
            cnt_d   = '0;
            first_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The mux select is derived from the next state so it registers alongside it.
    unique case (state_d)
      S_TRACK: sel_d = (cnt_d == '0) ? SEL_INJECT : SEL_RECIRC;
      S_HOLD:  sel_d = SEL_GATE;
      default: sel_d = SEL_INJECT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= CODE_MID;
      sel_q    <= SEL_INJECT;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rev_q    <= '0;
      run_q    <= '0;
      dir_q    <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      first_q  <= first_d;
    end
  end

  assign code      = code_q;
  assign sel       = sel_q;
  assign locked    = locked_q;
  assign lock_lost = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Bench for fmdll_lock_ctrl: directed walk through acquisition, injection, lock, loss,
// saturation, hold and reset, then random stimulus against an arithmetic reference model.
module tb_fmdll_lock_ctrl;

  localparam int CW   = 4;
  localparam int MW   = 2;
  localparam int LOCK = 8;
  localparam int LOSS = 4;
  localparam int MID  = 1 << (CW - 1);
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, en, hold_req, pd_valid, pd_late;
  logic [MW-1:0] m_div;
  logic [CW-1:0] code;
  logic [1:0]    sel, state;
  logic          locked, lock_lost;

  fmdll_lock_ctrl #(.CODE_W(CW), .M_W(MW), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold_req(hold_req), .m_div(m_div),
    .pd_valid(pd_valid), .pd_late(pd_late), .code(code), .sel(sel),
    .locked(locked), .lock_lost(lock_lost), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: SAR held as accumulated value plus current trial weight.
  int m_st, m_code, m_acc, m_w, m_cnt, m_rev, m_run, m_prev, m_first, m_locked, m_lost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_code = MID; m_acc = 0; m_w = MID; m_locked = 0; m_cnt = 0;
    m_rev = 0; m_run = 0; m_prev = 0; m_first = 1;
  endtask

  task automatic model_edge();
    m_lost = 0;
    if (!rst_n) begin
      m_st = 0; model_clear();
    end else if (!en) begin
      m_st = 0; model_clear();
    end else begin
      case (m_st)
        0: begin m_st = 1; m_acc = 0; m_w = MID; m_code = MID; end
        1: if (hold_req) m_st = 3;
           else if (pd_valid) begin
             if (!pd_late) m_acc += m_w;
             m_w = m_w / 2;
             m_code = m_acc + m_w;
             if (m_w == 0) begin m_st = 2; m_cnt = 0; m_first = 1; end
           end
        2: if (hold_req) m_st = 3;
           else begin
             m_cnt = (m_cnt >= int'(m_div)) ? 0 : m_cnt + 1;
             if (pd_valid) begin
               if (pd_late) m_code = (m_code > 0) ? m_code - 1 : 0;
               else         m_code = (m_code < MAXC) ? m_code + 1 : MAXC;
               if (m_first == 1) m_first = 0;
               else if (int'(pd_late) != m_prev) begin
                 m_rev = (m_rev + 1 > LOCK) ? LOCK : m_rev + 1;
                 m_run = 1;
                 if (m_rev == LOCK) m_locked = 1;
               end else begin
                 m_run = (m_run + 1 > LOSS) ? LOSS : m_run + 1;
                 m_rev = 0;
                 if (m_run == LOSS && m_locked == 1) begin
                   m_st = 1; model_clear(); m_lost = 1;
                 end
               end
               m_prev = int'(pd_late);
             end
           end
        default: if (!hold_req) begin m_st = 2; m_cnt = 0; m_first = 1; end
      endcase
    end
  endtask

  function automatic int model_sel();
    if (m_st == 2) return (m_cnt == 0) ? 1 : 0;
    if (m_st == 3) return 2;
    return 1;
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic e, input logic h, input logic [MW-1:0] md,
                      input logic v, input logic l);
    rst_n = r; en = e; hold_req = h; m_div = md; pd_valid = v; pd_late = l;
    @(posedge clk);
    model_edge();
    #1;
    check("model_code",   32'(code),      32'(m_code));
    check("model_sel",    32'(sel),       32'(model_sel()));
    check("model_locked", 32'(locked),    32'(m_locked));
    check("model_lost",   32'(lock_lost), 32'(m_lost));
    check("model_state",  32'(state),     32'(m_st));
  endtask

  int exp_sel[6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    logic e_r, h_r, late_r, drift, drift_dir;
    logic [MW-1:0] md_r;
    rst_n = 1'b0; en = 1'b0; hold_req = 1'b0; m_div = '0; pd_valid = 1'b0; pd_late = 1'b0;
    m_st = 0; m_lost = 0; model_clear();

    // Reset and idle: pd_valid is ignored.
    step(0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 2, 0, 0);
    check("rst_code", 32'(code), 32'(4'b1000));
    check("rst_sel", 32'(sel), 32'(2'b01));
    check("rst_state", 32'(state), 32'(2'b00));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2, 1, i[0]);
    check("idle_code", 32'(code), 32'(4'b1000));

    // SAR acquisition with late pattern 1,0,1,0.
    step(1, 1, 0, 2, 0, 0);
    check("sar_enter", 32'(state), 32'(2'b01));
    step(1, 1, 0, 2, 1, 1); check("sar1_code", 32'(code), 32'(4'b0100));
    step(1, 1, 0, 2, 0, 0); check("sar_nostrobe", 32'(code), 32'(4'b0100));
    step(1, 1, 0, 2, 1, 0); check("sar2_code", 32'(code), 32'(4'b0110));
    step(1, 1, 0, 2, 1, 1); check("sar3_code", 32'(code), 32'(4'b0101));
    check("sar3_state", 32'(state), 32'(2'b01));
    step(1, 1, 0, 2, 1, 0); check("sar4_code", 32'(code), 32'(4'b0101));
    check("sar4_state", 32'(state), 32'(2'b10));
    check("track_sel0", 32'(sel), 32'(2'b01));

    // Injection cadence with m_div=2.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 2, 0, 0);
      check($sformatf("inj_sel%0d", i), 32'(sel), 32'(exp_sel[i]));
    end

    // Lock: nine alternating strobes.
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 2, 1, (i % 2 == 0));
      check($sformatf("lock_code%0d", i), 32'(code), (i % 2 == 0) ? 32'd4 : 32'd5);
      check($sformatf("lock_flag%0d", i), 32'(locked), (i == 8) ? 32'd1 : 32'd0);
    end

    // Loss: four consecutive early decisions.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 2, 1, 0);
      check($sformatf("loss_code%0d", i), 32'(code), 32'(5 + i));
      check($sformatf("loss_nopulse%0d", i), 32'(lock_lost), 32'd0);
    end
    step(1, 1, 0, 2, 1, 0);
    check("loss_pulse", 32'(lock_lost), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_code", 32'(code), 32'(4'b1000));
    check("loss_state", 32'(state), 32'(2'b01));
    check("loss_sel", 32'(sel), 32'(2'b01));
    step(1, 1, 0, 2, 0, 0);
    check("loss_pulse_end", 32'(lock_lost), 32'd0);

    // Reacquire towards full scale, then saturate.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 0);
    check("reacq_code", 32'(code), 32'(4'b1111));
    check("reacq_state", 32'(state), 32'(2'b10));
    step(1, 1, 0, 0, 1, 0);
    check("sat_code", 32'(code), 32'(4'b1111));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      check($sformatf("mdiv0_sel%0d", i), 32'(sel), 32'(2'b01));
    end

    // m_div 3 -> 1 while cnt=3.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 3, 0, 0);
      check($sformatf("mdiv3_sel%0d", i), 32'(sel), 32'(2'b00));
    end
    step(1, 1, 0, 1, 0, 0); check("wrap_sel", 32'(sel), 32'(2'b01));
    step(1, 1, 0, 1, 0, 0); check("wrap_sel1", 32'(sel), 32'(2'b00));
    step(1, 1, 0, 1, 0, 0); check("wrap_sel2", 32'(sel), 32'(2'b01));

    // Hold with a coincident strobe, then release.
    step(1, 1, 1, 1, 1, 1);
    check("hold_state", 32'(state), 32'(2'b11));
    check("hold_sel", 32'(sel), 32'(2'b10));
    check("hold_code", 32'(code), 32'(4'b1111));
    step(1, 1, 1, 1, 1, 1);
    check("hold_code2", 32'(code), 32'(4'b1111));
    step(1, 1, 0, 1, 1, 1);
    check("release_state", 32'(state), 32'(2'b10));
    check("release_sel", 32'(sel), 32'(2'b01));
    check("release_code", 32'(code), 32'(4'b1111));
    step(1, 1, 0, 1, 1, 1);
    check("post_hold_step", 32'(code), 32'(4'b1110));

    // Reset during TRACK.
    step(0, 1, 0, 1, 1, 1);
    check("trk_rst_code", 32'(code), 32'(4'b1000));
    check("trk_rst_state", 32'(state), 32'(2'b00));
    check("trk_rst_sel", 32'(sel), 32'(2'b01));
    check("trk_rst_locked", 32'(locked), 32'd0);

    // Random phase: mostly alternating decisions with occasional one-sided drift.
    e_r = 1'b1; h_r = 1'b0; late_r = 1'b0; drift = 1'b0; drift_dir = 1'b0; md_r = 2'd2;
    for (int i = 0; i < 3000; i++) begin
      logic r_r, v_r;
      r_r = ($urandom_range(0, 499) != 0);
      if (e_r) e_r = ($urandom_range(0, 299) != 0);
      else     e_r = ($urandom_range(0, 2) == 0);
      if (h_r) h_r = ($urandom_range(0, 3) != 0);
      else     h_r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) md_r = MW'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        drift = ~drift; drift_dir = 1'($urandom_range(0, 1));
      end
      v_r = ($urandom_range(0, 1) == 1);
      if (v_r) begin
        if (drift) late_r = drift_dir;
        else if ($urandom_range(0, 7) == 0) late_r = 1'($urandom_range(0, 1));
        else late_r = ~late_r;
      end
      step(r_r, e_r, h_r, md_r, v_r, late_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmdll_lock_ctrl.md
Name: fmdll_lock_ctrl

Overview:
- Parametrised digital lock controller for the frequency-multiplying DLL. It runs in the reference (clk_ext) domain and consumes phase-detector decisions.
- Produces the DCDL delay code and the 2-bit clock-mux select (00 = recirculate clk_out, 01 = inject clk_ext, 10 = gate high).
- Adds binary-search (SAR) acquisition, ±1 tracking, periodic re-injection every m_div+1 reference cycles, lock/loss detection and a hold mode, with configurable code and ratio widths.

Parameters:
- CODE_W, 10, DCDL delay code width (>=2).
- M_W, 2, width of injection-interval input m_div.
- LOCK_CNT, 8, consecutive tracking direction reversals required to assert locked (>=1).
- LOSS_CNT, 4, consecutive same-direction tracking steps that declare loss of lock (>=2).

Ports:
- clk  in  1  reference clock (clk_ext); all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  controller enable; low forces IDLE.
- hold_req  in  1  freeze request (code frozen, mux gated).
- m_div  in  M_W  injection interval; injection period P = m_div+1 reference cycles.
- pd_valid  in  1  one-cycle strobe: phase-detector result available.
- pd_late  in  1  qualified by pd_valid. 1 = clk_out late, so reduce delay; 0 = early, so increase delay.
- code  out  CODE_W  DCDL delay code (registered).
- sel  out  2  clock-mux select (registered).
- locked  out  1  lock indication (registered).
- lock_lost  out  1  one-cycle pulse on loss of lock.
- state  out  2  00 IDLE, 01 SAR, 10 TRACK, 11 HOLD.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, code=1<<(CODE_W-1) (midscale), sel=01, locked=0, lock_lost=0.
  - All counters, bit index and previous-direction flag are cleared.
- All outputs are registered. A pd_valid sampled at edge k affects code/state/locked at edge k (visible after edge k). Latency is 1 cycle.
- IDLE:
  - sel=01, code=midscale, pd_valid ignored.
  - en=1 → SAR, with code=midscale and bit index idx=CODE_W-1.
- SAR:
  - sel=01 continuously.
  - On each pd_valid: if pd_late, clear code[idx]. Then if idx>0, set code[idx-1] and decrement idx. Otherwise go to TRACK.
  - Acquisition takes exactly CODE_W pd_valid strobes.
  - Cycles without pd_valid change nothing.
- TRACK:
  - Injection counter cnt runs 0..m_div and wraps. sel=01 when cnt==0, else 00. cnt=0 on TRACK entry.
  - m_div=0 gives sel=01 every cycle.
  - m_div is sampled live; if cnt>m_div after a change, cnt wraps to 0 on the next cycle.
  - On pd_valid: code-1 if pd_late, else code+1, saturating at 0 and 2^CODE_W-1. A saturated step still counts as a step in that direction.
  - Direction bookkeeping:
    - The first step after entering TRACK only records the direction.
    - A step opposite to the previous direction: reversal count +1 (saturating at LOCK_CNT), run count reset to 1.
    - A step in the same direction: run count +1, reversal count reset to 0.
  - Locking: reversal count reaching LOCK_CNT sets locked=1.
  - Loss of lock: run count reaching LOSS_CNT while locked=1 causes, on that edge:
    - locked=0 and lock_lost=1 for one cycle;
    - state→SAR, code=midscale, idx reset, counters cleared.
  - The same condition while locked=0 only holds state (no pulse, no SAR).
- HOLD:
  - Entered from SAR or TRACK when hold_req=1.
  - sel=10, code frozen, locked retained, pd_valid ignored, counters frozen.
  - hold_req=0 → TRACK; cnt restarts at 0 and the first step after HOLD only records direction.
  - A hold entered from SAR resumes as TRACK from the current partial code.
- Priority per edge: rst_n > en=0 (→IDLE, midscale, locked=0) > hold_req > pd_valid.
  - hold_req together with pd_valid: the strobe is dropped.
  - en falling mid-SAR/TRACK/HOLD: IDLE on the next edge, no lock_lost pulse.

Test Plan:
- Reset/idle, CODE_W=4: rst_n=0 for 2 cycles, en=0 → code=1000, sel=01, locked=0, state=00. Holding pd_valid pulses changes nothing.
- SAR, CODE_W=4: en=1, pd_late sequence 1,0,1,0 on four pd_valid strobes → code 0100, 0110, 0101, 0101, then state=TRACK after the 4th strobe.
- Injection, m_div=2, in TRACK: sel sequence 01,00,00,01,00,00…
  - m_div=0 → sel constant 01.
  - m_div changed 3→1 while cnt=3 → cnt wraps to 0 next cycle.
- Lock, LOCK_CNT=8: from code=0101, alternate pd_late 1,0,… for 9 strobes → code oscillates 0100/0101, locked=1 on the 9th strobe edge.
- Loss, LOSS_CNT=4, locked: four consecutive pd_late=0 → code +3 and then SAR entry with code=1000. lock_lost=1 for exactly one cycle, locked=0, sel=01.
- Saturation/hold/priority:
  - code=1111 with pd_late=0 → stays 1111.
  - hold_req=1 with pd_valid → sel=10, code unchanged. Release → TRACK, cnt=0.
  - rst_n=0 during TRACK → full reset values on the next edge.
